srt_frame_ctrl: RTL and testbench

//  Sequencer for the SRT/CORDIC point-processing datapath.
//  - Parses each AXIS frame from DMA MM2S into a coefficient-load phase and a point-stream phase.
//  - Drives coefficient writes, the load_matrix commit, vector valid and reference-point capture strobes.
//  - Regenerates m_tvalid/m_tlast at the datapath's fixed latency.
//  - Replaces free-running s_tready with credit-based flow control against the downstream output FIFO.

---
 rtl/srt_frame_ctrl.sv | 176 +++++++++++++++++
 tb/tb_srt_frame_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/srt_frame_ctrl.sv
// srt_frame_ctrl
//   Frame sequencer for the SRT/CORDIC point-processing datapath. Each AXIS
//   frame is split into a coefficient-load phase (COEF_BEATS beats) and a
//   point-stream phase. The block issues the coefficient writes, the
//   load_matrix commit pulse, vector valids and reference-point capture
//   strobes. It also regenerates m_tvalid/m_tlast at the datapath latency.
//   Input flow control is credit based against the downstream output FIFO.
//
//   Optional feature macro: SRT_CTRL_ERR_STAT_EN adds the sticky err_stat
//   output:
//     bit0 - tlast seen while loading coefficients
//     bit1 - fifo_pop at full credits
//     bit2 - s_tvalid high while draining
//
// Ports
//   aclk, areset            clock; synchronous active-high reset
//   s_tvalid/s_tlast/s_tready  AXIS slave handshake (data path not routed here)
//   coef_we, coef_addr      coefficient bank write strobe and lane0 word index
//   load_matrix             one-cycle coefficient commit pulse
//   vec_valid               current beat is a stream vector
//   ref_capture, ref_idx    store SRT output as reference point ref_idx
//   fifo_pop                downstream FIFO released one entry (credit return)
//   m_tvalid, m_tlast       output FIFO push and end-of-frame marker
//   busy                    frame in progress or results still in flight
module srt_frame_ctrl #(
    parameter int LANES      = 4,
    parameter int COEF_WORDS = 12,
    parameter int PIPE_LAT   = 46,
    parameter int SRT_LAT    = 6,
    parameter int NREF       = 3,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                                   aclk,
    input  logic                                   areset,
    input  logic                                   s_tvalid,
    input  logic                                   s_tlast,
    output logic                                   s_tready,
    output logic                                   coef_we,
    output logic [$clog2(COEF_WORDS)-1:0]          coef_addr,
    output logic                                   load_matrix,
    output logic                                   vec_valid,
    output logic                                   ref_capture,
    output logic [((NREF > 1) ? $clog2(NREF) : 1)-1:0] ref_idx,
    input  logic                                   fifo_pop,
    output logic                                   m_tvalid,
    output logic                                   m_tlast,
`ifdef SRT_CTRL_ERR_STAT_EN
    output logic [2:0]                             err_stat,
`endif
    output logic                                   busy
);

    localparam int COEF_BEATS = COEF_WORDS / LANES;
    localparam int CAW        = $clog2(COEF_WORDS);
    localparam int RIW        = (NREF > 1) ? $clog2(NREF) : 1;
    localparam int CW         = $clog2(FIFO_DEPTH + 1);
    localparam int BCMAX      = (COEF_BEATS > NREF) ? COEF_BEATS : NREF;
    localparam int BW         = $clog2(BCMAX + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_DRAIN  = 2'd3;

    logic [1:0]                   state;
    logic [BW-1:0]                beat_cnt;
    logic [CW-1:0]                credits;
    logic [PIPE_LAT-1:0]          vld_sr;
    logic [PIPE_LAT-1:0]          last_sr;
    logic [SRT_LAT-1:0]           ref_sr;
    logic [SRT_LAT-1:0][RIW-1:0]  ridx_sr;

    logic accept, coef_acc, strm_acc, is_ref, pop_ok;

    always_comb begin
        s_tready = 1'b1;
        if (state == S_STREAM)     s_tready = (credits != '0);
        else if (state == S_DRAIN) s_tready = 1'b0;
        accept    = s_tvalid & s_tready;
        coef_acc  = accept & ((state == S_IDLE) | (state == S_LOAD));
        strm_acc  = accept & (state == S_STREAM);
        coef_we   = coef_acc;
        coef_addr = '0;
        if (coef_acc && state == S_LOAD) coef_addr = CAW'(int'(beat_cnt) * LANES);
        vec_valid = strm_acc;
        // beat_cnt saturates at NREF, so it doubles as the reference slot index
        is_ref    = strm_acc & (int'(beat_cnt) < NREF);
        // a pop with all credits home has nothing to release
        pop_ok    = fifo_pop & (credits != CW'(FIFO_DEPTH));
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state       <= S_IDLE;
            beat_cnt    <= '0;
            credits     <= CW'(FIFO_DEPTH);
            vld_sr      <= '0;
            last_sr     <= '0;
            ref_sr      <= '0;
            ridx_sr     <= '0;
            load_matrix <= 1'b0;
        end else begin
            load_matrix <= 1'b0;
            vld_sr      <= {vld_sr[PIPE_LAT-2:0], strm_acc};
            last_sr     <= {last_sr[PIPE_LAT-2:0], strm_acc & s_tlast};
            ref_sr[0]   <= is_ref;
            ridx_sr[0]  <= is_ref ? RIW'(beat_cnt) : '0;
            for (int i = 1; i < SRT_LAT; i++) begin
                ref_sr[i]  <= ref_sr[i-1];
                ridx_sr[i] <= ridx_sr[i-1];
            end

            case ({strm_acc, pop_ok})
                2'b10:   credits <= credits - 1'b1;
                2'b01:   credits <= credits + 1'b1;
                default: ;
            endcase

            case (state)
                S_IDLE: if (coef_acc) begin
                    if (s_tlast) begin
                        beat_cnt <= '0;
                    end else if (COEF_BEATS == 1) begin
                        state       <= S_STREAM;
                        beat_cnt    <= '0;
                        load_matrix <= 1'b1;
                    end else begin
                        state    <= S_LOAD;
                        beat_cnt <= BW'(1);
                    end
                end
                S_LOAD: if (coef_acc) begin
                    // an early tlast abandons the load; the last committed bank stays live
                    if (s_tlast) begin
                        state    <= S_IDLE;
                        beat_cnt <= '0;
                    end else if (beat_cnt == BW'(COEF_BEATS - 1)) begin
                        state       <= S_STREAM;
                        beat_cnt    <= '0;
                        load_matrix <= 1'b1;
                    end else begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                S_STREAM: if (strm_acc) begin
                    if (s_tlast) begin
                        state    <= S_DRAIN;
                        beat_cnt <= '0;
                    end else if (int'(beat_cnt) < NREF) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: if (vld_sr == '0) state <= S_IDLE;
            endcase
        end
    end

`ifdef SRT_CTRL_ERR_STAT_EN
    always_ff @(posedge aclk) begin
        if (areset) begin
            err_stat <= '0;
        end else begin
            if (coef_acc & s_tlast)                          err_stat[0] <= 1'b1;
            if (fifo_pop & (credits == CW'(FIFO_DEPTH)))     err_stat[1] <= 1'b1;
            if ((state == S_DRAIN) & s_tvalid)               err_stat[2] <= 1'b1;
        end
    end
`endif

    assign m_tvalid    = vld_sr[PIPE_LAT-1];
    assign m_tlast     = last_sr[PIPE_LAT-1];
    assign ref_capture = ref_sr[SRT_LAT-1];
    assign ref_idx     = ridx_sr[SRT_LAT-1];
    assign busy        = (state != S_IDLE) | (|vld_sr);

endmodule

// File: tb/tb_srt_frame_ctrl.sv
// tb_srt_frame_ctrl
//   Directed bench for srt_frame_ctrl (PIPE_LAT=46, SRT_LAT=6, NREF=3,
//   FIFO_DEPTH=4). Inputs change 1 time unit after the rising edge, and a
//   negedge monitor logs output events with their cycle number. Checks
//   compare those logs against hand-derived cycle offsets.
module tb_srt_frame_ctrl;

    logic       aclk = 1'b0;
    logic       areset, s_tvalid, s_tlast, fifo_pop;
    logic       s_tready, coef_we, load_matrix, vec_valid, ref_capture;
    logic       m_tvalid, m_tlast, busy;
    logic [3:0] coef_addr;
    logic [1:0] ref_idx;
`ifdef SRT_CTRL_ERR_STAT_EN
    logic [2:0] err_stat;
`endif

    srt_frame_ctrl #(.FIFO_DEPTH(4)) dut (
        .aclk(aclk), .areset(areset), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .s_tready(s_tready), .coef_we(coef_we), .coef_addr(coef_addr),
        .load_matrix(load_matrix), .vec_valid(vec_valid), .ref_capture(ref_capture),
        .ref_idx(ref_idx), .fifo_pop(fifo_pop), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
`ifdef SRT_CTRL_ERR_STAT_EN
        .err_stat(err_stat),
`endif
        .busy(busy)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    int n_chk = 0;
    int n_err = 0;
    int blk = 0;
    int cw_q[$], ca_q[$], lm_q[$], vv_q[$], rf_q[$], ri_q[$], mv_q[$], ml_q[$];

    logic [13:0] outs;
    assign outs = {s_tready, coef_we, coef_addr, load_matrix, vec_valid,
                   ref_capture, ref_idx, m_tvalid, m_tlast, busy};

    always @(posedge aclk) cyc <= cyc + 1;

    always @(negedge aclk) begin
        if (coef_we)     begin cw_q.push_back(cyc); ca_q.push_back(int'(coef_addr)); end
        if (load_matrix) lm_q.push_back(cyc);
        if (vec_valid)   vv_q.push_back(cyc);
        if (ref_capture) begin rf_q.push_back(cyc); ri_q.push_back(int'(ref_idx)); end
        if (m_tvalid)    mv_q.push_back(cyc);
        if (m_tlast)     ml_q.push_back(cyc);
        if (s_tvalid && !s_tready) blk++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge aclk); #1; end
    endtask

    task automatic clr();
        cw_q.delete(); ca_q.delete(); lm_q.delete(); vv_q.delete();
        rf_q.delete(); ri_q.delete(); mv_q.delete(); ml_q.delete();
        blk = 0;
    endtask

    task automatic do_reset();
        areset = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0;
        tick(2);
        areset = 1'b0;
        clr();
    endtask

    // offer one beat until accepted; returns the cycle it was accepted in
    task automatic send(input logic last, output int acc);
        s_tvalid = 1'b1; s_tlast = last; acc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge aclk);
            if (s_tready) begin acc = cyc; break; end
        end
        @(posedge aclk); #1;
        s_tvalid = 1'b0; s_tlast = 1'b0;
        if (acc < 0) chk("send_timeout", 32'd0, 32'd1);
    endtask

    int c0, c1, c2, a, p0, pl, b0, bp0, bl;

    initial begin
        areset = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; fifo_pop = 1'b0;

        // reset state
        do_reset();
        chk("reset_outs", 32'(outs), 32'h2000);

        // frames 1/2: 3 coef beats, 5 points, pop tied high
        fifo_pop = 1'b1;
        send(1'b0, c0); send(1'b0, c1); send(1'b0, c2);
        chk("coef_acc1", c1, c0 + 1);
        chk("coef_acc2", c2, c0 + 2);
        send(1'b0, p0);
        for (int i = 1; i < 5; i++) send(i == 4, a);
        chk("pt_first", p0, c0 + 3);
        chk("pt_last", a, c0 + 7);
        tick(60);
        chk("coef_cnt", cw_q.size(), 3);
        for (int i = 0; i < 3; i++) chk($sformatf("coef_addr%0d", i), ca_q[i], i * 4);
        chk("lm_cnt", lm_q.size(), 1);
        chk("lm_cyc", lm_q[0], c0 + 3);
        chk("vv_cnt", vv_q.size(), 5);
        chk("mv_cnt", mv_q.size(), 5);
        for (int i = 0; i < 5; i++) chk($sformatf("mv_cyc%0d", i), mv_q[i], c0 + 3 + i + 46);
        chk("ml_cnt", ml_q.size(), 1);
        chk("ml_cyc", ml_q[0], c0 + 7 + 46);
        chk("ref_cnt", rf_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("ref_cyc%0d", i), rf_q[i], c0 + 3 + i + 6);
            chk($sformatf("ref_idx%0d", i), ri_q[i], i);
        end
        chk("busy_done1", busy, 0);

        // credit flow: depth 4, no pops
        do_reset();
        fifo_pop = 1'b0;
        for (int i = 0; i < 3; i++) send(1'b0, a);
        s_tvalid = 1'b1;
        tick(15);
        chk("cred_acc4", vv_q.size(), 4);
        chk("cred_block", s_tready, 0);
        fifo_pop = 1'b1; tick(1);
        chk("rdy_after_pop", s_tready, 1);
        tick(1);
        fifo_pop = 1'b0;
        chk("rdy_pop_acc", s_tready, 1);
        tick(5);
        chk("cred_acc6", vv_q.size(), 6);
        chk("cred_block2", s_tready, 0);
        s_tlast = 1'b1; fifo_pop = 1'b1; tick(1);
        fifo_pop = 1'b0; tick(1);
        s_tvalid = 1'b0; s_tlast = 1'b0;
        tick(60);
        chk("cred_mv", mv_q.size(), 7);
        chk("cred_ml", ml_q.size(), 1);
        chk("busy_done3", busy, 0);

        // abort on tlast during coefficient load
        do_reset();
        send(1'b0, a); send(1'b1, a);
        tick(2);
        chk("abort_lm", lm_q.size(), 0);
        chk("abort_busy", busy, 0);
        send(1'b0, c0); send(1'b0, a); send(1'b0, a);
        send(1'b1, a);
        tick(60);
        chk("abort_cw", cw_q.size(), 5);
        chk("abort_addr2", ca_q[2], 0);
        chk("abort_addr4", ca_q[4], 8);
        chk("reload_lm", lm_q.size(), 1);
        chk("reload_lm_cyc", lm_q[0], c0 + 3);
        chk("reload_ml", ml_q.size(), 1);
`ifdef SRT_CTRL_ERR_STAT_EN
        chk("err_stat", err_stat, 3'b001);
`endif

        // reset in the middle of a 30-point frame
        do_reset();
        fifo_pop = 1'b1;
        for (int i = 0; i < 3; i++) send(1'b0, a);
        for (int i = 0; i < 20; i++) send(1'b0, a);
        areset = 1'b1; tick(1);
        areset = 1'b0;
        chk("mid_reset_outs", 32'(outs), 32'h2000);
        clr();
        tick(60);
        chk("mid_reset_mv", mv_q.size(), 0);
        chk("mid_reset_ml", ml_q.size(), 0);
        fifo_pop = 1'b0;
        for (int i = 0; i < 3; i++) send(1'b0, a);
        s_tvalid = 1'b1;
        tick(8);
        s_tvalid = 1'b0;
        chk("mid_reset_cred", vv_q.size(), 4);

        // back-to-back frames with s_tvalid held high
        do_reset();
        fifo_pop = 1'b1;
        for (int i = 0; i < 3; i++) send(1'b0, a);
        send(1'b0, p0); send(1'b1, pl);
        send(1'b0, b0);
        for (int i = 0; i < 2; i++) send(1'b0, a);
        send(1'b0, bp0); send(1'b1, bl);
        tick(60);
        chk("b2b_block", blk, 47);
        chk("b2b_restart", b0, pl + 48);
        chk("b2b_mv", mv_q.size(), 4);
        chk("b2b_mv0", mv_q[0], p0 + 46);
        chk("b2b_mv1", mv_q[1], pl + 46);
        chk("b2b_mv2", mv_q[2], bp0 + 46);
        chk("b2b_mv3", mv_q[3], bl + 46);
        chk("b2b_ml", ml_q.size(), 2);
        chk("b2b_ml0", ml_q[0], pl + 46);
        chk("b2b_ml1", ml_q[1], bl + 46);
        chk("b2b_lm", lm_q.size(), 2);
        chk("busy_done6", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
